// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority bus arbiter.
package bus_arb_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic [1:0] {
    StIdle,
    StGranted,
    StOwned
  } arb_state_e;

  function automatic int unsigned owner_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: first set request at or after the pointer (round-robin),
// or lowest set index (fixed priority).
module rr_priority_picker
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 6,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned OWNER_W  = owner_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [OWNER_W-1:0] winner,
  output logic               any_valid
);

  localparam int unsigned IdxW = OWNER_W + 1;

  logic [IdxW-1:0] start;
  logic [IdxW-1:0] idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    start     = (ARB_MODE == ARB_RR) ? {1'b0, ptr} : '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Extra index bit lets start+i exceed NUM_REQ-1 before wrapping back.
      idx = start + IdxW'(i);
      if (idx >= IdxW'(NUM_REQ)) begin
        idx = idx - IdxW'(NUM_REQ);
      end
      if (!any_valid && req[idx[OWNER_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[OWNER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Bus arbiter: grants one requester at a time, holds the grant while the bus is busy and
// revokes a grant that is never used within GRANT_TIMEOUT cycles.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 6,
  parameter int unsigned ARB_MODE      = ARB_RR,
  parameter int unsigned GRANT_TIMEOUT = 16,
  localparam int unsigned OWNER_W      = owner_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] in_reqcyc,
  input  logic               in_bus_busy,
  output logic [NUM_REQ-1:0] out_grant,
  output logic [OWNER_W-1:0] out_owner,
  output logic               out_owner_valid,
  output logic               out_timeout
);

  localparam int unsigned WaitW = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [WaitW-1:0]   wait_q, wait_d;

  logic [OWNER_W-1:0] winner;
  logic               any_valid;
  logic               owner_req;
  logic               timeout_hit;

  rr_priority_picker #(
    .NUM_REQ  (NUM_REQ),
    .ARB_MODE (ARB_MODE),
    .OWNER_W  (OWNER_W)
  ) u_picker (
    .req       (in_reqcyc),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign owner_req   = in_reqcyc[owner_q];
  assign timeout_hit = (GRANT_TIMEOUT != 0) && (wait_q == WaitW'(GRANT_TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) state_d = StGranted;
      end
      StGranted: begin
        if (in_bus_busy) begin
          state_d = StOwned;
        end else if (!owner_req || timeout_hit) begin
          state_d = StIdle;
        end
      end
      StOwned: begin
        if (!in_bus_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    owner_d   = owner_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    wait_d    = wait_q;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        owner_d = '0;
        valid_d = 1'b0;
        wait_d  = '0;
        if (any_valid) begin
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          valid_d         = 1'b1;
          wait_d          = WaitW'(1);
          if (ARB_MODE == ARB_RR) begin
            ptr_d = (winner == OWNER_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          end
        end
      end
      StGranted: begin
        if (in_bus_busy) begin
          wait_d = '0;
        end else if (!owner_req || timeout_hit) begin
          grant_d   = '0;
          owner_d   = '0;
          valid_d   = 1'b0;
          wait_d    = '0;
          // A requester that withdraws on the deadline cycle is a normal release.
          timeout_d = owner_req;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      StOwned: begin
        wait_d = '0;
        if (!in_bus_busy) begin
          grant_d = '0;
          owner_d = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        grant_d = '0;
        owner_d = '0;
        valid_d = 1'b0;
        wait_d  = '0;
      end
    endcase
  end

  assign out_grant       = grant_q;
  assign out_owner       = owner_q;
  assign out_owner_valid = valid_q;
  assign out_timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed scoreboard bench: round-robin instance (timeout 4) plus a fixed-priority instance
// sharing the same stimulus.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] in_reqcyc = '0;
  logic       in_bus_busy = 1'b0;

  logic [5:0] g0, g1;
  logic [2:0] o0, o1;
  logic       v0, v1, t0, t1;

  typedef struct packed {
    logic [5:0] req;
    logic       busy;
    logic [5:0] grant;
    logic       to;
  } step_t;

  typedef struct packed {
    logic [5:0] grant;
    logic [2:0] owner;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .NUM_REQ       (6),
    .ARB_MODE      (1),
    .GRANT_TIMEOUT (4)
  ) u_rr (
    .clk             (clk),
    .reset           (reset),
    .in_reqcyc       (in_reqcyc),
    .in_bus_busy     (in_bus_busy),
    .out_grant       (g0),
    .out_owner       (o0),
    .out_owner_valid (v0),
    .out_timeout     (t0)
  );

  bus_arbiter_rr #(
    .NUM_REQ       (6),
    .ARB_MODE      (0),
    .GRANT_TIMEOUT (4)
  ) u_fix (
    .clk             (clk),
    .reset           (reset),
    .in_reqcyc       (in_reqcyc),
    .in_bus_busy     (in_bus_busy),
    .out_grant       (g1),
    .out_owner       (o1),
    .out_owner_valid (v1),
    .out_timeout     (t1)
  );

  function automatic step_t st(input logic [5:0] req, input logic busy,
                               input logic [5:0] grant, input logic to);
    step_t s;
    s.req = req; s.busy = busy; s.grant = grant; s.to = to;
    return s;
  endfunction

  function automatic exp_t expect_of(input step_t s);
    exp_t e;
    e.grant = s.grant;
    e.owner = '0;
    for (int i = 0; i < 6; i++) if (s.grant[i]) e.owner = 3'(i);
    e.valid = |s.grant;
    e.to    = s.to;
    return e;
  endfunction

  task automatic tick(input logic [5:0] req, input logic busy);
    in_reqcyc   = req;
    in_bus_busy = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0; in_reqcyc = '0; in_bus_busy = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('0);
    e = sb.pop_front();
    n_vec++;
    if ({g0, o0, v0, t0} !== e) begin
      n_bad++;
      $display("FAIL reset_rr: got %b/%0d/%b/%b want %b/%0d/%b/%b", g0, o0, v0, t0,
               e.grant, e.owner, e.valid, e.to);
    end
    sb.push_back('0);
    e = sb.pop_front();
    n_vec++;
    if ({g1, o1, v1, t1} !== e) begin
      n_bad++;
      $display("FAIL reset_fix: got %b/%0d/%b/%b want %b/%0d/%b/%b", g1, o1, v1, t1,
               e.grant, e.owner, e.valid, e.to);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    step_t s[$];
    exp_t  e;
    s.push_back(st(6'b000100, 1'b0, 6'b000100, 1'b0));
    s.push_back(st(6'b000100, 1'b1, 6'b000100, 1'b0));
    s.push_back(st(6'b000100, 1'b1, 6'b000100, 1'b0));
    s.push_back(st(6'b000000, 1'b1, 6'b000100, 1'b0));
    s.push_back(st(6'b000000, 1'b0, 6'b000000, 1'b0));
    foreach (s[i]) begin
      sb.push_back(expect_of(s[i]));
      tick(s[i].req, s[i].busy);
      e = sb.pop_front();
      n_vec++;
      if ({g0, o0, v0, t0} !== e) begin
        n_bad++;
        $display("FAIL single[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, g0, o0, v0, t0,
                 e.grant, e.owner, e.valid, e.to);
      end
    end
  endtask

  task automatic test_rr_sweep();
    step_t s[$];
    exp_t  e;
    test_reset();
    for (int k = 0; k < 7; k++) begin
      s.push_back(st(6'b111111, 1'b0, 6'(1 << (k % 6)), 1'b0));
      s.push_back(st(6'b111111, 1'b1, 6'(1 << (k % 6)), 1'b0));
      s.push_back(st(6'b111111, 1'b0, 6'b000000, 1'b0));
    end
    foreach (s[i]) begin
      sb.push_back(expect_of(s[i]));
      tick(s[i].req, s[i].busy);
      e = sb.pop_front();
      n_vec++;
      if ({g0, o0, v0, t0} !== e) begin
        n_bad++;
        $display("FAIL sweep[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, g0, o0, v0, t0,
                 e.grant, e.owner, e.valid, e.to);
      end
    end
  endtask

  task automatic test_wrap();
    step_t s[$];
    exp_t  e;
    test_reset();
    // Grant requester 4 and release it unused, leaving the pointer at 5.
    s.push_back(st(6'b010000, 1'b0, 6'b010000, 1'b0));
    s.push_back(st(6'b000000, 1'b0, 6'b000000, 1'b0));
    s.push_back(st(6'b100001, 1'b0, 6'b100000, 1'b0));
    s.push_back(st(6'b100001, 1'b1, 6'b100000, 1'b0));
    s.push_back(st(6'b100001, 1'b0, 6'b000000, 1'b0));
    s.push_back(st(6'b100001, 1'b0, 6'b000001, 1'b0));
    s.push_back(st(6'b100001, 1'b1, 6'b000001, 1'b0));
    s.push_back(st(6'b100001, 1'b0, 6'b000000, 1'b0));
    s.push_back(st(6'b100001, 1'b0, 6'b100000, 1'b0));
    s.push_back(st(6'b100001, 1'b1, 6'b100000, 1'b0));
    s.push_back(st(6'b000000, 1'b0, 6'b000000, 1'b0));
    foreach (s[i]) begin
      sb.push_back(expect_of(s[i]));
      tick(s[i].req, s[i].busy);
      e = sb.pop_front();
      n_vec++;
      if ({g0, o0, v0, t0} !== e) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, g0, o0, v0, t0,
                 e.grant, e.owner, e.valid, e.to);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s[$];
    exp_t  e;
    for (int k = 0; k < 4; k++) s.push_back(st(6'b000010, 1'b0, 6'b000010, 1'b0));
    s.push_back(st(6'b000010, 1'b0, 6'b000000, 1'b1));
    s.push_back(st(6'b000000, 1'b0, 6'b000000, 1'b0));
    // Busy arrives on the fourth granted cycle: ownership wins over revocation.
    for (int k = 0; k < 4; k++) s.push_back(st(6'b000010, 1'b0, 6'b000010, 1'b0));
    s.push_back(st(6'b000010, 1'b1, 6'b000010, 1'b0));
    s.push_back(st(6'b000010, 1'b1, 6'b000010, 1'b0));
    s.push_back(st(6'b000000, 1'b0, 6'b000000, 1'b0));
    foreach (s[i]) begin
      sb.push_back(expect_of(s[i]));
      tick(s[i].req, s[i].busy);
      e = sb.pop_front();
      n_vec++;
      if ({g0, o0, v0, t0} !== e) begin
        n_bad++;
        $display("FAIL timeout[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, g0, o0, v0, t0,
                 e.grant, e.owner, e.valid, e.to);
      end
    end
  endtask

  task automatic test_idle_busy();
    step_t s[$];
    exp_t  e;
    s.push_back(st(6'b000000, 1'b1, 6'b000000, 1'b0));
    s.push_back(st(6'b001000, 1'b1, 6'b001000, 1'b0));
    s.push_back(st(6'b001000, 1'b1, 6'b001000, 1'b0));
    s.push_back(st(6'b000000, 1'b0, 6'b000000, 1'b0));
    foreach (s[i]) begin
      sb.push_back(expect_of(s[i]));
      tick(s[i].req, s[i].busy);
      e = sb.pop_front();
      n_vec++;
      if ({g0, o0, v0, t0} !== e) begin
        n_bad++;
        $display("FAIL idle_busy[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, g0, o0, v0,
                 t0, e.grant, e.owner, e.valid, e.to);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s[$];
    exp_t  e;
    tick(6'b000001, 1'b0);
    tick(6'b000001, 1'b1);
    #2;
    sb.push_back('0);
    reset = 1'b0;
    #1;
    e = sb.pop_front();
    n_vec++;
    if ({g0, o0, v0, t0} !== e) begin
      n_bad++;
      $display("FAIL async_reset: got %b/%0d/%b/%b want %b/%0d/%b/%b", g0, o0, v0, t0,
               e.grant, e.owner, e.valid, e.to);
    end
    #2;
    reset = 1'b1;
    s.push_back(st(6'b000100, 1'b0, 6'b000100, 1'b0));
    s.push_back(st(6'b000000, 1'b0, 6'b000000, 1'b0));
    foreach (s[i]) begin
      sb.push_back(expect_of(s[i]));
      tick(s[i].req, s[i].busy);
      e = sb.pop_front();
      n_vec++;
      if ({g0, o0, v0, t0} !== e) begin
        n_bad++;
        $display("FAIL resume[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, g0, o0, v0, t0,
                 e.grant, e.owner, e.valid, e.to);
      end
    end
  endtask

  task automatic test_fixed();
    step_t s[$];
    exp_t  e;
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(6'b101000, 1'b0, 6'b001000, 1'b0));
      s.push_back(st(6'b101000, 1'b1, 6'b001000, 1'b0));
      s.push_back(st(6'b101000, 1'b0, 6'b000000, 1'b0));
    end
    foreach (s[i]) begin
      sb.push_back(expect_of(s[i]));
      tick(s[i].req, s[i].busy);
      e = sb.pop_front();
      n_vec++;
      if ({g1, o1, v1, t1} !== e) begin
        n_bad++;
        $display("FAIL fixed[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, g1, o1, v1, t1,
                 e.grant, e.owner, e.valid, e.to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_sweep();
    test_wrap();
    test_timeout();
    test_idle_busy();
    test_async_reset();
    test_fixed();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
